// File: rtl/nios2_ht18_wang_fu_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer (s1 port).
// 16-bit data, 5-bit word address, zero wait states, read latency 1.
interface nios2_ht18_wang_fu_multi_timer_if;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios2_ht18_wang_fu_multi_timer.sv
// Multi-channel Avalon-MM interval timer: NUM_CH prescaled down-counters, combined irq.
// Optional macro TIMER_PULSE_OUT_EN adds a registered per-channel timeout pulse output.
module nios2_ht18_wang_fu_multi_timer #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 32,
  parameter int PRESCALE_W   = 8,
  parameter int RESET_PERIOD = 49999
) (
  input  logic                             clk,
  input  logic                             reset_n,
  nios2_ht18_wang_fu_multi_timer_if.slave  bus,
  output logic                             irq
`ifdef TIMER_PULSE_OUT_EN
  ,
  output logic [NUM_CH-1:0]                pulse_out
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  localparam logic [CNT_W-1:0]      CNT_RST  = CNT_W'(RESET_PERIOD);
  localparam logic [CNT_W-1:0]      CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [PRESCALE_W-1:0] PC_ZERO  = PRESCALE_W'(0);
  localparam logic [PRESCALE_W-1:0] PC_ONE   = PRESCALE_W'(1);

  function automatic logic [15:0] lo16(input logic [CNT_W-1:0] v);
    logic [31:0] t;
    t = 32'(v);
    return t[15:0];
  endfunction

  function automatic logic [15:0] hi16(input logic [CNT_W-1:0] v);
    logic [31:0] t;
    t = 32'(v);
    return t[31:16];
  endfunction

  run_state_t             state_r    [NUM_CH];
  run_state_t             state_n    [NUM_CH];
  logic [CNT_W-1:0]       period_r   [NUM_CH];
  logic [CNT_W-1:0]       period_n   [NUM_CH];
  logic [CNT_W-1:0]       cnt_r      [NUM_CH];
  logic [CNT_W-1:0]       cnt_n      [NUM_CH];
  logic [CNT_W-1:0]       snap_r     [NUM_CH];
  logic [CNT_W-1:0]       snap_n     [NUM_CH];
  logic [PRESCALE_W-1:0]  prescale_r [NUM_CH];
  logic [PRESCALE_W-1:0]  prescale_n [NUM_CH];
  logic [PRESCALE_W-1:0]  pc_r       [NUM_CH];
  logic [PRESCALE_W-1:0]  pc_n       [NUM_CH];
  logic [15:0]            chan_rd_s  [NUM_CH];

  logic [NUM_CH-1:0] to_r, to_n, ito_r, ito_n, cont_r, cont_n;
  logic [NUM_CH-1:0] reload_r, reload_n;
  logic [NUM_CH-1:0] sel_s, start_s, stop_s, run_s, tick_s, evt_s, irq_vec_s;
  logic              wr_s;
  logic [1:0]        ch_s;
  logic [2:0]        rsel_s;
  logic [15:0]       rd_s, readdata_r;

  assign wr_s   = bus.chipselect & ~bus.write_n;
  assign ch_s   = bus.address[4:3];
  assign rsel_s = bus.address[2:0];

  // Per-channel write decode, control strobes and tick/timeout qualification.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sel_s[i]     = wr_s && (ch_s == 2'(i));
      start_s[i]   = sel_s[i] && (rsel_s == 3'd1) && bus.writedata[2];
      stop_s[i]    = sel_s[i] && (rsel_s == 3'd1) && bus.writedata[3];
      run_s[i]     = (state_r[i] == ST_RUN);
      tick_s[i]    = run_s[i] && (pc_r[i] == PC_ZERO) && !start_s[i];
      // A pending forced reload pre-empts the counter, so it can never raise a timeout.
      evt_s[i]     = tick_s[i] && (cnt_r[i] == CNT_ZERO) && !reload_r[i];
      irq_vec_s[i] = to_r[i] & ito_r[i];
    end
  end

  // Next-state for the RUN machine, counters and register file.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_n[i]    = state_r[i];
      period_n[i]   = period_r[i];
      snap_n[i]     = snap_r[i];
      prescale_n[i] = prescale_r[i];
      ito_n[i]      = ito_r[i];
      cont_n[i]     = cont_r[i];
      reload_n[i]   = 1'b0;

      case (state_r[i])
        ST_IDLE: state_n[i] = start_s[i] ? ST_RUN : ST_IDLE;
        ST_RUN: begin
          if (start_s[i]) begin
            state_n[i] = ST_RUN;
          end else if (stop_s[i] || reload_r[i] || (evt_s[i] && !cont_r[i])) begin
            state_n[i] = ST_IDLE;
          end else begin
            state_n[i] = ST_RUN;
          end
        end
        default: state_n[i] = ST_IDLE;
      endcase

      if (start_s[i]) begin
        pc_n[i] = prescale_r[i];
      end else if (run_s[i]) begin
        pc_n[i] = (pc_r[i] == PC_ZERO) ? prescale_r[i] : (pc_r[i] - PC_ONE);
      end else begin
        pc_n[i] = pc_r[i];
      end

      if (reload_r[i]) begin
        cnt_n[i] = period_r[i];
      end else if (tick_s[i]) begin
        cnt_n[i] = (cnt_r[i] == CNT_ZERO) ? period_r[i] : (cnt_r[i] - CNT_ONE);
      end else begin
        cnt_n[i] = cnt_r[i];
      end

      // Set has priority over a status-write clear so no timeout is lost.
      to_n[i] = evt_s[i] ? 1'b1 : ((sel_s[i] && (rsel_s == 3'd0)) ? 1'b0 : to_r[i]);

      if (sel_s[i]) begin
        case (rsel_s)
          3'd1: begin
            ito_n[i]  = bus.writedata[0];
            cont_n[i] = bus.writedata[1];
          end
          3'd2: begin
            period_n[i][15:0] = bus.writedata;
            reload_n[i]       = 1'b1;
          end
          3'd3: begin
            period_n[i][CNT_W-1:16] = bus.writedata[CNT_W-17:0];
            reload_n[i]             = 1'b1;
          end
          3'd4, 3'd5: snap_n[i]     = cnt_r[i];
          3'd7:       prescale_n[i] = bus.writedata[PRESCALE_W-1:0];
          default:    reload_n[i]   = 1'b0;
        endcase
      end else begin
        reload_n[i] = 1'b0;
      end
    end
  end

  // Read multiplexer; unimplemented channels contribute nothing and read as zero.
  always_comb begin
    rd_s = 16'h0000;
    for (int i = 0; i < NUM_CH; i++) begin
      case (rsel_s)
        3'd0:    chan_rd_s[i] = {14'h0000, run_s[i], to_r[i]};
        3'd1:    chan_rd_s[i] = {14'h0000, cont_r[i], ito_r[i]};
        3'd2:    chan_rd_s[i] = lo16(period_r[i]);
        3'd3:    chan_rd_s[i] = hi16(period_r[i]);
        3'd4:    chan_rd_s[i] = lo16(snap_r[i]);
        3'd5:    chan_rd_s[i] = hi16(snap_r[i]);
        3'd6:    chan_rd_s[i] = 16'(irq_vec_s);
        3'd7:    chan_rd_s[i] = 16'(prescale_r[i]);
        default: chan_rd_s[i] = 16'h0000;
      endcase
      rd_s = rd_s | ((ch_s == 2'(i)) ? chan_rd_s[i] : 16'h0000);
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i]    <= ST_IDLE;
        period_r[i]   <= CNT_RST;
        cnt_r[i]      <= CNT_RST;
        snap_r[i]     <= CNT_ZERO;
        prescale_r[i] <= PC_ZERO;
        pc_r[i]       <= PC_ZERO;
      end
      to_r     <= {NUM_CH{1'b0}};
      ito_r    <= {NUM_CH{1'b0}};
      cont_r   <= {NUM_CH{1'b0}};
      reload_r <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i]    <= state_n[i];
        period_r[i]   <= period_n[i];
        cnt_r[i]      <= cnt_n[i];
        snap_r[i]     <= snap_n[i];
        prescale_r[i] <= prescale_n[i];
        pc_r[i]       <= pc_n[i];
      end
      to_r     <= to_n;
      ito_r    <= ito_n;
      cont_r   <= cont_n;
      reload_r <= reload_n;
    end
  end

  // Registered read data, one cycle after the address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 16'h0000;
    end else begin
      readdata_r <= rd_s;
    end
  end

  assign bus.readdata = readdata_r;
  assign irq          = |irq_vec_s;

`ifdef TIMER_PULSE_OUT_EN
  logic [NUM_CH-1:0] pulse_r;

  // One-clock pulse following each channel timeout, independent of ITO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_r <= {NUM_CH{1'b0}};
    end else begin
      pulse_r <= evt_s;
    end
  end

  assign pulse_out = pulse_r;
`endif

endmodule

// File: tb/tb_nios2_ht18_wang_fu_multi_timer.sv
// Directed self-checking bench for the multi-channel interval timer (NUM_CH=2 defaults).
module tb_nios2_ht18_wang_fu_multi_timer;

  logic clk = 1'b0;
  logic reset_n;
  logic irq;
`ifdef TIMER_PULSE_OUT_EN
  logic [1:0] pulse_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  nios2_ht18_wang_fu_multi_timer_if bus_if ();

  nios2_ht18_wang_fu_multi_timer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus_if),
    .irq       (irq)
`ifdef TIMER_PULSE_OUT_EN
    ,
    .pulse_out (pulse_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic rd_check(input logic [4:0] a, input logic [15:0] exp, input string tag);
    logic [15:0] d;
    @(negedge clk);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    @(negedge clk);
    d = bus_if.readdata;
    bus_if.chipselect = 1'b0;
    check(tag, 32'(d), 32'(exp));
  endtask

  initial begin
    int pulses;
    int consec;
    logic prev;

    bus_if.address    = 5'd0;
    bus_if.writedata  = 16'h0000;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    reset_n           = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_readdata", 32'(bus_if.readdata), 32'd0);
    reset_n = 1'b1;

    // Reset values of the register file
    rd_check(5'd2, 16'd49999, "rst_ch0_period_l");
    rd_check(5'd3, 16'd0, "rst_ch0_period_h");
    rd_check(5'd0, 16'd0, "rst_ch0_status");
    rd_check(5'd10, 16'd49999, "rst_ch1_period_l");
    rd_check(5'd7, 16'd0, "rst_ch0_prescale");
    rd_check(5'd4, 16'd0, "rst_ch0_snap_l");
    check("rst_irq", 32'(irq), 32'd0);

    // ch0 continuous, period 4, no prescale: timeout every 5 clocks
    bus_write(5'd2, 16'd4);
    bus_write(5'd7, 16'd0);
    bus_write(5'd1, 16'h0007);
    repeat (4) @(negedge clk);
    check("ch0_irq_before_first_to", 32'(irq), 32'd0);
    @(negedge clk);
    check("ch0_irq_first_to", 32'(irq), 32'd1);
    bus_write(5'd0, 16'h0000);
    check("ch0_irq_cleared", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    check("ch0_irq_still_low", 32'(irq), 32'd0);
    @(negedge clk);
    check("ch0_irq_second_to", 32'(irq), 32'd1);

    // Status write coinciding with a timeout keeps TO set
    bus_write(5'd0, 16'h0000);
    check("ch0_irq_clear2", 32'(irq), 32'd0);
    @(negedge clk);
    bus_write(5'd0, 16'h0000);
    check("ch0_irq_set_vs_clear", 32'(irq), 32'd1);
    rd_check(5'd0, 16'h0003, "ch0_status_set_vs_clear");

    // Stop ch0 with ITO off, then ch1 one-shot period 2 prescale 3
    bus_write(5'd1, 16'h0008);
    bus_write(5'd0, 16'h0000);
    check("ch0_stopped_irq", 32'(irq), 32'd0);
    bus_write(5'd10, 16'd2);
    bus_write(5'd15, 16'd3);
    bus_write(5'd9, 16'h0005);
    repeat (11) @(negedge clk);
    check("ch1_irq_before_to", 32'(irq), 32'd0);
    @(negedge clk);
    check("ch1_irq_at_12", 32'(irq), 32'd1);
    rd_check(5'd14, 16'h0002, "ch1_irq_pend");
    rd_check(5'd6, 16'h0002, "ch0_irq_pend_alias");
    rd_check(5'd8, 16'h0001, "ch1_status_oneshot_done");
    bus_write(5'd8, 16'h0000);
    repeat (20) @(negedge clk);
    check("ch1_single_timeout", 32'(irq), 32'd0);
    rd_check(5'd8, 16'h0000, "ch1_status_idle");
    bus_write(5'd12, 16'h0000);
    rd_check(5'd12, 16'd2, "ch1_cnt_reloaded");
    rd_check(5'd15, 16'd3, "ch1_prescale");

    // ch0 period 100, snapshot after 10 ticks, then forced reload to 7
    bus_write(5'd2, 16'd100);
    bus_write(5'd1, 16'h0007);
    repeat (9) @(negedge clk);
    bus_write(5'd4, 16'h0000);
    rd_check(5'd4, 16'd90, "ch0_snap_l_90");
    rd_check(5'd5, 16'd0, "ch0_snap_h_0");
    bus_write(5'd2, 16'd7);
    bus_write(5'd4, 16'h0000);
    rd_check(5'd4, 16'd7, "ch0_forced_reload_cnt");
    rd_check(5'd0, 16'h0000, "ch0_forced_reload_status");
    check("ch0_forced_reload_irq", 32'(irq), 32'd0);

    // START|STOP together: START wins; strobes read back as zero
    bus_write(5'd1, 16'h000C);
    rd_check(5'd0, 16'h0002, "ch0_start_wins");
    rd_check(5'd1, 16'h0000, "ch0_control_readback");

    // Out-of-range channel: reads zero, writes ignored
    rd_check(5'd24, 16'h0000, "ch3_read_zero");
    bus_write(5'd26, 16'd3);
    bus_write(5'd25, 16'h0007);
    bus_write(5'd31, 16'h00FF);
    rd_check(5'd26, 16'h0000, "ch3_period_read_zero");
    rd_check(5'd2, 16'd7, "ch0_period_untouched");
    rd_check(5'd10, 16'd2, "ch1_period_untouched");
    rd_check(5'd15, 16'd3, "ch1_prescale_untouched");
    rd_check(5'd0, 16'h0001, "ch0_oneshot_expired");
    check("no_irq_ito_off", 32'(irq), 32'd0);

`ifdef TIMER_PULSE_OUT_EN
    // ch0 continuous period 7: timeouts 8 clocks apart, 1-clock pulses
    bus_write(5'd1, 16'h0006);
    pulses = 0;
    consec = 0;
    prev   = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (pulse_out[0]) begin
        pulses++;
      end
      if (pulse_out[0] && prev) begin
        consec++;
      end
      prev = pulse_out[0];
    end
    check("pulse_count", 32'(pulses), 32'd3);
    check("pulse_width_1clk", 32'(consec), 32'd0);
    check("pulse_ch1_idle", 32'(pulse_out[1]), 32'd0);
`else
    pulses = 0;
    consec = 0;
    prev   = 1'b0;
`endif

    // Asynchronous reset in the middle of a count
    bus_write(5'd1, 16'h0007);
    repeat (3) @(negedge clk);
    check("pre_reset_irq", 32'(irq), 32'd1);
    rd_check(5'd2, 16'd7, "pre_reset_period");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_irq", 32'(irq), 32'd0);
    check("async_reset_readdata", 32'(bus_if.readdata), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_check(5'd2, 16'd49999, "post_reset_period");
    rd_check(5'd0, 16'h0000, "post_reset_status");
    rd_check(5'd1, 16'h0000, "post_reset_control");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
